// File: rtl/umult_sched_if.sv
// Request, response and multiplier-side signals of the umult_sched round-robin scheduler.
interface umult_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [IDW-1:0]           rsp_id;
    logic [2*WIDTH-1:0]       rsp_data;
    logic                     rsp_err;
    logic                     mul_start;
    logic [WIDTH-1:0]         mul_a;
    logic [WIDTH-1:0]         mul_b;
    logic                     mul_done;
    logic [2*WIDTH-1:0]       mul_result;

    // The scheduler sits on the slave side; requesters and the multiplier together form the master.
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_done, mul_result,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, mul_start, mul_a, mul_b
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_done, mul_result,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/umult_sched.sv
// Round-robin scheduler sharing one multi-cycle unsigned multiplier among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining UMULT_SCHED_TIMEOUT_EN.
module umult_sched #(
    parameter int NUM_REQ        = 4,
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic          clk,
    input logic          reset,
    umult_sched_if.slave bus
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state;
    state_t             state_next;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     winner;
    logic [IDW-1:0]     id_q;
    logic               found;
    logic               timeout;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] data_q;
    int                 idx;

    if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("umult_sched: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    // Search starts at rr_ptr so the most recently served requester has lowest priority.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_next    = state;
        bus.req_ready = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    bus.req_ready[winner] = 1'b1;
                    state_next            = ISSUE;
                end
            end
            ISSUE:   state_next = WAIT;
            WAIT:    if (bus.mul_done || timeout) state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            id_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            data_q <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && found) begin
                id_q   <= winner;
                a_q    <= bus.req_a[int'(winner)*WIDTH +: WIDTH];
                b_q    <= bus.req_b[int'(winner)*WIDTH +: WIDTH];
                rr_ptr <= (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + IDW'(1);
            end
            if (state == WAIT) begin
                if (bus.mul_done)
                    data_q <= bus.mul_result;
                else if (timeout)
                    data_q <= '0;
            end
        end
    end

`ifdef UMULT_SCHED_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDW-1:0] wd;
    logic           err_q;

    // wd holds the number of WAIT cycles already spent, so the last allowed cycle is TIMEOUT_CYCLES-1.
    assign timeout = (state == WAIT) && !bus.mul_done && (wd == WDW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wd    <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wd    <= '0;
                err_q <= 1'b0;
            end else if (state == WAIT) begin
                wd <= wd + WDW'(1);
                if (bus.mul_done)
                    err_q <= 1'b0;
                else if (timeout)
                    err_q <= 1'b1;
            end
        end
    end

    assign bus.rsp_err = err_q;
`else
    assign timeout     = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.mul_start = (state == ISSUE);
    assign bus.mul_a     = a_q;
    assign bus.mul_b     = b_q;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = data_q;
endmodule
